// File: rtl/mem_read_streamer.sv
// mem_read_streamer: reads a contiguous run of words from the read port of a
// pseudo-2-port memory and presents them on a valid/ready stream. A small skid
// FIFO absorbs downstream backpressure. A read is issued only when a FIFO slot
// is free, so no read is ever dropped.
// Optional feature: define MEM_READ_STREAMER_STRIDE_EN to add a `stride` input.
// The stride is latched on start, and the address then advances by the stride
// (mod HEIGHT) instead of by 1.
module mem_read_streamer #(
    parameter int WIDTH      = 16,
    parameter int HEIGHT     = 128,
    parameter int FIFO_DEPTH = 4,
    parameter int LW         = $clog2(HEIGHT) + 1,
    localparam int AW        = $clog2(HEIGHT)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [AW-1:0]    base_addr,
    input  logic [LW-1:0]    length,
`ifdef MEM_READ_STREAMER_STRIDE_EN
    input  logic [AW-1:0]    stride,
`endif
    output logic             busy,
    output logic             done,
    output logic [AW-1:0]    mem_read_addr,
    output logic             mem_read_en,
    input  logic [WIDTH-1:0] mem_qout,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {IDLE, STREAM, DRAIN, DONE} state_t;

    state_t           state;
    logic [AW-1:0]    addr;
    logic [LW-1:0]    remaining;
    logic [AW-1:0]    step;
    logic [AW-1:0]    next_addr;
    logic [AW+1:0]    addr_sum;

    logic [WIDTH-1:0] fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    fifo_count;
    logic             push;
    logic             pop;

`ifdef MEM_READ_STREAMER_STRIDE_EN
    logic [AW-1:0]    stride_q;
    assign step = stride_q;
`else
    assign step = AW'(1);
`endif

    // The full check ignores a same-cycle pop. This costs one bubble when the
    // FIFO is full, but it keeps read_en off the pop path.
    assign push          = (state == STREAM) && (fifo_count < CW'(FIFO_DEPTH));
    assign pop           = out_valid && out_ready;
    assign mem_read_en   = push;
    assign mem_read_addr = push ? addr : '0;
    assign out_valid     = (fifo_count != '0);
    assign out_data      = fifo_mem[rd_ptr];

    // Next read address: addr + step wrapped into 0..HEIGHT-1. The sum is
    // below 3*HEIGHT, so two conditional subtractions cover any HEIGHT.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no latch is inferred.
        next_addr = '0;
        addr_sum  = {2'b00, addr} + {2'b00, step};
        if (addr_sum >= (AW+2)'(2 * HEIGHT))
            next_addr = AW'(addr_sum - (AW+2)'(2 * HEIGHT));
        else if (addr_sum >= (AW+2)'(HEIGHT))
            next_addr = AW'(addr_sum - (AW+2)'(HEIGHT));
        else
            next_addr = AW'(addr_sum);
    end

    // Run sequencer: start latching, read issue, drain wait and done pulse.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (rst) begin
            state     <= IDLE;
            addr      <= '0;
            remaining <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
`ifdef MEM_READ_STREAMER_STRIDE_EN
            stride_q  <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        addr      <= base_addr;
                        remaining <= length;
                        busy      <= 1'b1;
`ifdef MEM_READ_STREAMER_STRIDE_EN
                        stride_q  <= stride;
`endif
                        if (length == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= STREAM;
                        end
                    end
                end
                STREAM: begin
                    if (push) begin
                        addr      <= next_addr;
                        remaining <= remaining - LW'(1);
                        if (remaining == LW'(1))
                            state <= DRAIN;
                    end
                end
                DRAIN: begin
                    // Leave once the last word has been taken by the consumer.
                    if (fifo_count == '0 || (fifo_count == CW'(1) && pop)) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // FIFO pointers and occupancy. A same-cycle push and pop leaves the count unchanged.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CW'(1);
                2'b01:   fifo_count <= fifo_count - CW'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // FIFO storage captures the memory word on every issued read.
    always_ff @(posedge clk) begin
        // NOTE: storage is not reset; out_valid qualifies its contents.
        if (push)
            fifo_mem[wr_ptr] <= mem_qout;
    end

endmodule

// File: tb/tb_mem_read_streamer.sv
// Self-checking bench for mem_read_streamer. It uses a behavioural memory, an
// address/data expectation queue computed from each run's base, length and
// stride, and randomized runs with random backpressure.
module tb_mem_read_streamer;

    localparam int WIDTH  = 16;
    localparam int HEIGHT = 128;
    localparam int AW     = $clog2(HEIGHT);
    localparam int LW     = AW + 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [AW-1:0]    base_addr;
    logic [LW-1:0]    length;
`ifdef MEM_READ_STREAMER_STRIDE_EN
    logic [AW-1:0]    stride;
`endif
    logic             busy;
    logic             done;
    logic [AW-1:0]    mem_read_addr;
    logic             mem_read_en;
    logic [WIDTH-1:0] mem_qout;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;

    logic [WIDTH-1:0] mem_model [HEIGHT];
    assign mem_qout = mem_model[mem_read_addr];

    mem_read_streamer #(.WIDTH(WIDTH), .HEIGHT(HEIGHT), .FIFO_DEPTH(4), .LW(LW)) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .base_addr     (base_addr),
        .length        (length),
`ifdef MEM_READ_STREAMER_STRIDE_EN
        .stride        (stride),
`endif
        .busy          (busy),
        .done          (done),
        .mem_read_addr (mem_read_addr),
        .mem_read_en   (mem_read_en),
        .mem_qout      (mem_qout),
        .out_data      (out_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Per-run statistics gathered by the monitor.
    int exp_addr [$];
    int exp_data [$];
    int rd_cnt, pop_cnt, valid_cnt, done_cnt, done_cyc, first_valid_cyc, idle_addr_bad;
    int start_edge;
    bit rand_ready = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        #1;
        if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    end

    // Monitor: check every issued read address and every delivered word against the queues.
    always @(negedge clk) begin
        if (!rst) begin
            if (mem_read_en) begin
                rd_cnt++;
                check("rd_addr", 32'(mem_read_addr), (exp_addr.size() > 0) ? exp_addr.pop_front() : -1);
            end else if (mem_read_addr != '0) begin
                idle_addr_bad++;
            end
            if (out_valid) begin
                valid_cnt++;
                if (first_valid_cyc < 0) first_valid_cyc = cyc;
            end
            if (out_valid && out_ready) begin
                pop_cnt++;
                check("out_data", 32'(out_data), (exp_data.size() > 0) ? exp_data.pop_front() : -1);
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    // Build the run's expectations from base/length/stride, then pulse start.
    task automatic start_run(input int base, input int len, input int str);
        exp_addr.delete();
        exp_data.delete();
        for (int i = 0; i < len; i++) begin
            int a;
            a = (base + i * str) % HEIGHT;
            exp_addr.push_back(a);
            exp_data.push_back(int'(mem_model[a]));
        end
        rd_cnt = 0; pop_cnt = 0; valid_cnt = 0; done_cnt = 0;
        done_cyc = -1; first_valid_cyc = -1; idle_addr_bad = 0;
        @(posedge clk); #1;
        start     = 1'b1;
        base_addr = AW'(base);
        length    = LW'(len);
`ifdef MEM_READ_STREAMER_STRIDE_EN
        stride    = AW'(str);
`endif
        start_edge = cyc + 1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic finish_run(input string tag, input int len);
        int budget;
        budget = 4 * len + 60;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done_cnt != 0) break;
        end
        repeat (3) @(negedge clk);
        check({tag, "_done_cnt"}, done_cnt, 1);
        check({tag, "_reads"}, rd_cnt, len);
        check({tag, "_pops"}, pop_cnt, len);
        check({tag, "_left"}, exp_data.size(), 0);
        check({tag, "_idle_addr"}, idle_addr_bad, 0);
        check({tag, "_busy"}, 32'(busy), 0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; base_addr = '0; length = '0; out_ready = 1'b1;
`ifdef MEM_READ_STREAMER_STRIDE_EN
        stride = '0;
`endif
        for (int i = 0; i < HEIGHT; i++) mem_model[i] = WIDTH'(i + 100);
        rd_cnt = 0; pop_cnt = 0; valid_cnt = 0; done_cnt = 0;
        done_cyc = -1; first_valid_cyc = -1; idle_addr_bad = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_valid", 32'(out_valid), 0);
        check("rst_rd_en", 32'(mem_read_en), 0);
        check("rst_rd_addr", 32'(mem_read_addr), 0);

        // Basic run: 105..112, first valid at cycle N+2, done at cycle N+10.
        start_run(5, 8, 1);
        finish_run("basic", 8);
        check("basic_first_valid", first_valid_cyc, start_edge + 1);
        check("basic_done_cyc", done_cyc, start_edge + 9);

        // Backpressure: only FIFO_DEPTH reads while out_ready is low.
        out_ready = 1'b0;
        start_run(0, 10, 1);
        repeat (18) @(negedge clk);
        check("bp_reads_held", rd_cnt, 4);
        check("bp_rd_en_low", 32'(mem_read_en), 0);
        check("bp_head", 32'(out_data), 100);
        check("bp_valid", 32'(out_valid), 1);
        check("bp_no_pop", pop_cnt, 0);
        @(posedge clk); #1 out_ready = 1'b1;
        finish_run("bp", 10);

        // Wrap at the top of memory: 126, 127, 0, 1.
        start_run(HEIGHT - 2, 4, 1);
        finish_run("wrap", 4);

        // Zero length: done one cycle after start, nothing read or delivered.
        start_run(10, 0, 1);
        finish_run("zero", 0);
        check("zero_done_cyc", done_cyc, start_edge);
        check("zero_valid", valid_cnt, 0);

        // A start pulse while busy is ignored.
        start_run(30, 6, 1);
        @(posedge clk); #1;
        start = 1'b1; base_addr = AW'(60); length = LW'(3);
        @(posedge clk); #1 start = 1'b0;
        finish_run("ign", 6);
        repeat (5) @(negedge clk);
        check("ign_no_rerun", rd_cnt, 6);

        // Reset in the middle of a run.
        start_run(40, 8, 1);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (pop_cnt >= 3) break;
        end
        check("mid_pops_before_rst", pop_cnt, 3);
        @(posedge clk); #1 rst = 1'b1;
        exp_addr.delete();
        exp_data.delete();
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("mid_busy", 32'(busy), 0);
        check("mid_valid", 32'(out_valid), 0);
        check("mid_done", 32'(done), 0);
        check("mid_rd_en", 32'(mem_read_en), 0);
        check("mid_done_cnt", done_cnt, 0);
        start_run(20, 2, 1);
        finish_run("post_rst", 2);

`ifdef MEM_READ_STREAMER_STRIDE_EN
        start_run(1, 4, 3);
        finish_run("stride3", 4);
        start_run(1, 4, 0);
        finish_run("stride0", 4);
        start_run(120, 5, 50);
        finish_run("stride_wrap", 5);
`endif

        // Randomized runs with random memory contents and random backpressure.
        for (int i = 0; i < HEIGHT; i++) mem_model[i] = WIDTH'($urandom);
        rand_ready = 1'b1;
        for (int r = 0; r < 8; r++) begin
            int b, l, s;
            b = $urandom_range(0, HEIGHT - 1);
            l = (r == 7) ? HEIGHT : $urandom_range(1, 24);
            s = 1;
`ifdef MEM_READ_STREAMER_STRIDE_EN
            s = $urandom_range(0, HEIGHT - 1);
`endif
            start_run(b, l, s);
            finish_run("rand", l);
        end
        rand_ready = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
